// File: rtl/iot_filter_gen.sv
// rtl/iot_filter_gen.sv - byte-serial grouped word filter with selectable max/min/avg/range/peak functions
module iot_filter_gen #(
    parameter int DW  = 128,
    parameter int GRP = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_en,
    input  logic [7:0]    iot_in,
    input  logic [2:0]    fn_sel,
    input  logic [DW-1:0] lo_bound,
    input  logic [DW-1:0] hi_bound,
    output logic          busy,
    output logic          valid,
    output logic [DW-1:0] iot_out
);
    localparam int NB = DW / 8;
    localparam int LG = $clog2(GRP);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] FN_MAX     = 3'b001;
    localparam logic [2:0] FN_MIN     = 3'b010;
    localparam logic [2:0] FN_AVG     = 3'b011;
    localparam logic [2:0] FN_EXT     = 3'b100;
    localparam logic [2:0] FN_EXC     = 3'b101;
    localparam logic [2:0] FN_PEAKMAX = 3'b110;
    localparam logic [2:0] FN_PEAKMIN = 3'b111;

    typedef enum logic [1:0] {
        S_READ = 2'd0,
        S_PROC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic          accept;
    logic          do_proc;
    logic          do_out;
    logic          last_byte;
    logic          last_word;

    logic [BW-1:0] byte_cnt;
    logic [BW-1:0] slot;
    logic [LG-1:0] word_cnt;
    logic [DW-1:0] word;
    logic [2:0]    fn_lat;

    logic [DW-1:0]    grp_max;
    logic [DW-1:0]    grp_min;
    logic [DW+LG-1:0] sum;
    logic [DW-1:0]    glob_max;
    logic [DW-1:0]    glob_min;
    logic             peak_max;
    logic             peak_min;

    logic [DW-1:0]    grp_max_n;
    logic [DW-1:0]    grp_min_n;
    logic [DW+LG-1:0] sum_n;
    logic [DW-1:0]    glob_max_n;
    logic [DW-1:0]    glob_min_n;
    logic             peak_max_n;
    logic             peak_min_n;
    logic             ext;
    logic             exc;
    logic             res_valid;
    logic [DW-1:0]    res_data;

    // State register; busy is registered from the next state so it rises
    // the cycle after the last byte and falls on return to READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_READ;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_READ);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_READ:  if (accept && last_byte) state_next = S_PROC;
            S_PROC:  state_next = S_OUT;
            S_OUT:   state_next = S_READ;
            default: state_next = S_READ;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        do_proc = 1'b0;
        do_out  = 1'b0;
        case (state)
            S_READ:  accept  = in_en && !busy;
            S_PROC:  do_proc = 1'b1;
            S_OUT:   do_out  = 1'b1;
            default: accept  = 1'b0;
        endcase
    end

    assign last_byte = (byte_cnt == BW'(NB - 1));
    assign last_word = (word_cnt == LG'(GRP - 1));
    assign slot      = BW'(NB - 1) - byte_cnt;

    // Byte assembly, MSB byte first; fn_sel is captured only at the start of a group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            word     <= '0;
            fn_lat   <= '0;
        end else if (accept) begin
            word[int'(slot)*8 +: 8] <= iot_in;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
            if (byte_cnt == '0 && word_cnt == '0)
                fn_lat <= fn_sel;
        end
    end

    // Statistics including the word being processed.
    always_comb begin
        grp_max_n  = (word > grp_max)  ? word : grp_max;
        grp_min_n  = (word < grp_min)  ? word : grp_min;
        sum_n      = sum + {{LG{1'b0}}, word};
        glob_max_n = (word > glob_max) ? word : glob_max;
        glob_min_n = (word < glob_min) ? word : glob_min;
        peak_max_n = peak_max || (word > glob_max);
        peak_min_n = peak_min || (word < glob_min);
        ext        = (lo_bound < word) && (word < hi_bound);
        exc        = (word < lo_bound) || (word > hi_bound);
    end

    always_comb begin
        res_valid = 1'b0;
        res_data  = word;
        case (fn_lat)
            FN_MAX: begin
                res_valid = last_word;
                res_data  = grp_max_n;
            end
            FN_MIN: begin
                res_valid = last_word;
                res_data  = grp_min_n;
            end
            FN_AVG: begin
                res_valid = last_word;
                res_data  = sum_n[DW+LG-1:LG];
            end
            FN_EXT:  res_valid = ext;
            FN_EXC:  res_valid = exc;
            FN_PEAKMAX: begin
                res_valid = last_word && peak_max_n;
                res_data  = glob_max_n;
            end
            FN_PEAKMIN: begin
                res_valid = last_word && peak_min_n;
                res_data  = glob_min_n;
            end
            default: res_valid = 1'b0;
        endcase
    end

    // Result is registered at the end of PROC so valid is seen during OUT;
    // group bookkeeping advances at the end of OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            iot_out  <= '0;
            word_cnt <= '0;
            grp_max  <= '0;
            grp_min  <= '1;
            sum      <= '0;
            glob_max <= '0;
            glob_min <= '1;
            peak_max <= 1'b0;
            peak_min <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (do_proc) begin
                grp_max  <= grp_max_n;
                grp_min  <= grp_min_n;
                sum      <= sum_n;
                glob_max <= glob_max_n;
                glob_min <= glob_min_n;
                peak_max <= peak_max_n;
                peak_min <= peak_min_n;
                valid    <= res_valid;
                if (res_valid)
                    iot_out <= res_data;
            end
            if (do_out) begin
                word_cnt <= word_cnt + 1'b1;
                if (last_word) begin
                    grp_max  <= '0;
                    grp_min  <= '1;
                    sum      <= '0;
                    peak_max <= 1'b0;
                    peak_min <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iot_filter_gen.sv
// tb/tb_iot_filter_gen.sv - directed self-checking bench for iot_filter_gen
module tb_iot_filter_gen;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_en;
    logic [7:0]    iot_in;
    logic [2:0]    fn_sel;
    logic [DW-1:0] lo_bound;
    logic [DW-1:0] hi_bound;
    logic          busy;
    logic          valid;
    logic [DW-1:0] iot_out;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] gw [8];
    logic [7:0]    gv;
    logic [DW-1:0] go;
    logic          busy_chk;
    logic          sv;
    logic [DW-1:0] so;

    iot_filter_gen #(.DW(DW), .GRP(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_en    (in_en),
        .iot_in   (iot_in),
        .fn_sel   (fn_sel),
        .lo_bound (lo_bound),
        .hi_bound (hi_bound),
        .busy     (busy),
        .valid    (valid),
        .iot_out  (iot_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one word byte-by-byte, then samples PROC, OUT and the return to READ.
    task automatic send_word(input logic [DW-1:0] w, input logic cb,
                             output logic v, output logic [DW-1:0] o);
        for (int i = 0; i < DW/8; i++) begin
            in_en  = 1'b1;
            iot_in = w[8*(DW/8-1-i) +: 8];
            @(negedge clk);
        end
        in_en = 1'b0;
        if (cb) check("busy_proc", DW'(busy), DW'(1));
        if (cb) check("valid_proc", DW'(valid), DW'(0));
        @(negedge clk);
        v = valid;
        o = iot_out;
        if (cb) check("busy_out", DW'(busy), DW'(1));
        @(negedge clk);
        if (cb) check("busy_read", DW'(busy), DW'(0));
        if (cb) check("valid_read", DW'(valid), DW'(0));
    endtask

    task automatic run_group(input logic [2:0] f);
        logic          v;
        logic [DW-1:0] o;
        fn_sel = f;
        gv = '0;
        go = '0;
        for (int i = 0; i < 8; i++) begin
            send_word(gw[i], busy_chk && (i == 0), v, o);
            gv[i] = v;
            if (v) go = o;
        end
    endtask

    task automatic do_reset();
        in_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        in_en    = 1'b0;
        iot_in   = 8'h00;
        fn_sel   = 3'b000;
        lo_bound = '0;
        hi_bound = '0;
        busy_chk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  DW'(busy),  DW'(0));
        check("rst_valid", DW'(valid), DW'(0));
        check("rst_out",   iot_out,    DW'(0));
        rst = 1'b0;
        @(negedge clk);

        // MAX over 1..8
        for (int i = 0; i < 8; i++) gw[i] = DW'(i + 1);
        busy_chk = 1'b1;
        run_group(3'b001);
        busy_chk = 1'b0;
        check("max_v", DW'(gv), DW'(8'h80));
        check("max_o", go, DW'(8));

        // AVG of all ones, then of 0..7
        for (int i = 0; i < 8; i++) gw[i] = '1;
        run_group(3'b011);
        check("avg1_v", DW'(gv), DW'(8'h80));
        check("avg1_o", go, {DW{1'b1}});
        for (int i = 0; i < 8; i++) gw[i] = DW'(i);
        run_group(3'b011);
        check("avg2_v", DW'(gv), DW'(8'h80));
        check("avg2_o", go, DW'(3));

        // EXT / EXC with words on and between the bounds
        lo_bound = DW'(8'h10) << 120;
        hi_bound = DW'(8'h20) << 120;
        for (int i = 0; i < 8; i += 4) begin
            gw[i]   = DW'(8'h10) << 120;
            gw[i+1] = DW'(8'h15) << 120;
            gw[i+2] = DW'(8'h20) << 120;
            gw[i+3] = DW'(8'h30) << 120;
        end
        run_group(3'b100);
        check("ext_v", DW'(gv), DW'(8'h22));
        check("ext_o", go, DW'(8'h15) << 120);
        run_group(3'b101);
        check("exc_v", DW'(gv), DW'(8'h88));
        check("exc_o", go, DW'(8'h30) << 120);
        lo_bound = DW'(8'h20) << 120;
        hi_bound = DW'(8'h10) << 120;
        run_group(3'b100);
        check("ext_inv_v", DW'(gv), DW'(0));

        // PEAKMAX from a clean global state
        do_reset();
        for (int i = 0; i < 8; i++) gw[i] = '0;
        run_group(3'b110);
        check("pk_zero_v", DW'(gv), DW'(0));
        for (int i = 0; i < 8; i++) gw[i] = DW'(i + 1);
        gw[2] = DW'(8'h50);
        run_group(3'b110);
        check("pk1_v", DW'(gv), DW'(8'h80));
        check("pk1_o", go, DW'(8'h50));
        gw[2] = DW'(8'h40);
        run_group(3'b110);
        check("pk2_v", DW'(gv), DW'(0));
        gw[5] = DW'(8'h60);
        run_group(3'b110);
        check("pk3_v", DW'(gv), DW'(8'h80));
        check("pk3_o", go, DW'(8'h60));
        run_group(3'b110);
        check("pk4_v", DW'(gv), DW'(0));

        // fn_sel change mid-group is ignored until the next group
        gw[0] = DW'(5); gw[1] = DW'(9); gw[2] = DW'(2); gw[3] = DW'(7);
        gw[4] = DW'(3); gw[5] = DW'(8); gw[6] = DW'(4); gw[7] = DW'(6);
        fn_sel = 3'b001;
        gv = '0;
        go = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) fn_sel = 3'b010;
            send_word(gw[i], 1'b0, sv, so);
            gv[i] = sv;
            if (sv) go = so;
        end
        check("sw_max_v", DW'(gv), DW'(8'h80));
        check("sw_max_o", go, DW'(9));
        run_group(3'b010);
        check("sw_min_v", DW'(gv), DW'(8'h80));
        check("sw_min_o", go, DW'(2));

        // Reset partway through word 4 of a PEAKMIN group
        fn_sel = 3'b111;
        for (int i = 0; i < 4; i++) send_word(DW'(8'h20 + i), 1'b0, sv, so);
        for (int i = 0; i < 5; i++) begin
            in_en  = 1'b1;
            iot_in = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        in_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",  DW'(busy),  DW'(0));
        check("mid_rst_valid", DW'(valid), DW'(0));
        check("mid_rst_out",   iot_out,    DW'(0));
        rst = 1'b0;
        @(negedge clk);
        gw[0] = DW'(8'h37); gw[1] = DW'(8'h35); gw[2] = DW'(8'h33); gw[3] = DW'(8'h31);
        gw[4] = DW'(8'h32); gw[5] = DW'(8'h34); gw[6] = DW'(8'h36); gw[7] = DW'(8'h38);
        run_group(3'b111);
        check("pkmin_v", DW'(gv), DW'(8'h80));
        check("pkmin_o", go, DW'(8'h31));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
